// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART configuration write sequencer.
//   seq_state_e  : sequencer states (IDLE, ISSUE, RESP, DONE, ERR)
//   ERR_*        : err_code encodings reported on abort
//   RESP_*       : AXI write-response encodings
//   resp_is_okay : response classification helper
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } seq_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RESP    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any response other than OKAY counts as a failed write attempt.
    function automatic logic resp_is_okay(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/uart_cfg_timer.sv
// Per-attempt cycle counter for the UART configuration sequencer.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   clear  : zero the count (wins over enable)
//   enable : count this cycle
//   tc     : count has reached TIMEOUT-1 (holds there until cleared)
module uart_cfg_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int            CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE    = CW'(1'b1);

    logic [CW-1:0] count_r;

    // Attempt counter: cleared on a new attempt, saturates at the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != TC_VAL)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/uart_cfg_seq.sv
// UART configuration sequencer: after a start pulse, writes a fixed table of
// N_ENTRY registers over an AXI-lite style write channel, retrying on error
// responses and aborting on retry exhaustion or per-attempt timeout.
//   clk, rst                  : clock; asynchronous active-high reset
//   start                     : one-cycle pulse, ignored while busy
//   aw_addr/aw_valid/aw_ready : write-address channel (BASE + ENTRY_OFF[idx])
//   w_data/w_valid/w_ready    : write-data channel (ENTRY_DATA[idx])
//   b_resp/b_valid/b_ready    : write-response channel
//   busy/done/error           : status levels
//   err_idx/err_code          : entry and cause of an abort (01 resp, 10 timeout)
// Table entry 0 is the most significant element of ENTRY_OFF / ENTRY_DATA.
module uart_cfg_seq
    import uart_cfg_pkg::*;
#(
    parameter int                    N_ENTRY    = 3,
    parameter logic [31:0]           BASE       = 32'h0001_0000,
    parameter logic [N_ENTRY*8-1:0]  ENTRY_OFF  = {8'h00, 8'h1C, 8'h10},
    parameter logic [N_ENTRY*32-1:0] ENTRY_DATA = {32'd2604, 32'h20, 32'h48},
    parameter int                    TIMEOUT    = 1024,
    parameter int                    MAX_RETRY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] aw_addr,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] w_data,
    output logic        w_valid,
    input  logic        w_ready,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  err_idx,
    output logic [1:0]  err_code
);

    localparam int            RW        = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1'b1);
    localparam logic [3:0]    LAST_IDX  = 4'(N_ENTRY - 1);

    function automatic logic [31:0] entry_addr(input logic [3:0] i);
        return BASE + {24'h00_0000, ENTRY_OFF[(N_ENTRY - 1 - int'(i)) * 8 +: 8]};
    endfunction

    function automatic logic [31:0] entry_data(input logic [3:0] i);
        return ENTRY_DATA[(N_ENTRY - 1 - int'(i)) * 32 +: 32];
    endfunction

    seq_state_e     state_r,    state_nxt;
    logic [3:0]     idx_r,      idx_nxt;
    logic [RW-1:0]  retry_r,    retry_nxt;
    logic           aw_valid_r, aw_valid_nxt;
    logic           w_valid_r,  w_valid_nxt;
    logic           aw_done_r,  aw_done_nxt;
    logic           w_done_r,   w_done_nxt;
    logic           b_ready_r,  b_ready_nxt;
    logic [31:0]    aw_addr_r,  aw_addr_nxt;
    logic [31:0]    w_data_r,   w_data_nxt;
    logic           busy_r,     busy_nxt;
    logic           done_r,     done_nxt;
    logic           error_r,    error_nxt;
    logic [3:0]     err_idx_r,  err_idx_nxt;
    logic [1:0]     err_code_r, err_code_nxt;

    logic aw_hs_s, w_hs_s, b_hs_s;
    logic launch_s;
    logic timer_en_s;
    logic timer_tc_s;

    assign aw_hs_s    = aw_valid_r & aw_ready;
    assign w_hs_s     = w_valid_r & w_ready;
    assign b_hs_s     = b_ready_r & b_valid;
    assign timer_en_s = (state_r == ST_ISSUE) || (state_r == ST_RESP);

    uart_cfg_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (launch_s),
        .enable (timer_en_s),
        .tc     (timer_tc_s)
    );

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            retry_r    <= {RW{1'b0}};
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            b_ready_r  <= 1'b0;
            aw_addr_r  <= 32'h0000_0000;
            w_data_r   <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_idx_r  <= 4'd0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_nxt;
            idx_r      <= idx_nxt;
            retry_r    <= retry_nxt;
            aw_valid_r <= aw_valid_nxt;
            w_valid_r  <= w_valid_nxt;
            aw_done_r  <= aw_done_nxt;
            w_done_r   <= w_done_nxt;
            b_ready_r  <= b_ready_nxt;
            aw_addr_r  <= aw_addr_nxt;
            w_data_r   <= w_data_nxt;
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
            error_r    <= error_nxt;
            err_idx_r  <= err_idx_nxt;
            err_code_r <= err_code_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state_r;
        idx_nxt      = idx_r;
        retry_nxt    = retry_r;
        aw_valid_nxt = aw_valid_r;
        w_valid_nxt  = w_valid_r;
        aw_done_nxt  = aw_done_r;
        w_done_nxt   = w_done_r;
        b_ready_nxt  = b_ready_r;
        aw_addr_nxt  = aw_addr_r;
        w_data_nxt   = w_data_r;
        done_nxt     = done_r;
        error_nxt    = error_r;
        err_idx_nxt  = err_idx_r;
        err_code_nxt = err_code_r;
        launch_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    idx_nxt      = 4'd0;
                    retry_nxt    = {RW{1'b0}};
                    done_nxt     = 1'b0;
                    error_nxt    = 1'b0;
                    err_idx_nxt  = 4'd0;
                    err_code_nxt = ERR_NONE;
                    launch_s     = 1'b1;
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_ISSUE: begin
                // Each channel retires on its own; its valid drops after its handshake.
                if (aw_hs_s) begin
                    aw_valid_nxt = 1'b0;
                    aw_done_nxt  = 1'b1;
                end else begin
                    aw_done_nxt = aw_done_r;
                end
                if (w_hs_s) begin
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_done_nxt = w_done_r;
                end
                // The RESP move uses the registered done flags, giving one
                // settling cycle after the last handshake.
                if (timer_tc_s) begin
                    state_nxt    = ST_ERR;
                    aw_valid_nxt = 1'b0;
                    w_valid_nxt  = 1'b0;
                    b_ready_nxt  = 1'b0;
                    error_nxt    = 1'b1;
                    err_idx_nxt  = idx_r;
                    err_code_nxt = ERR_TIMEOUT;
                end else if (aw_done_r && w_done_r) begin
                    state_nxt   = ST_RESP;
                    b_ready_nxt = 1'b1;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_RESP: begin
                // A response in the terminal-count cycle still wins over the timeout.
                if (b_hs_s) begin
                    b_ready_nxt = 1'b0;
                    if (resp_is_okay(b_resp)) begin
                        if (idx_r == LAST_IDX) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt   = idx_r + 4'd1;
                            retry_nxt = {RW{1'b0}};
                            launch_s  = 1'b1;
                        end
                    end else if (retry_r < RETRY_MAX) begin
                        retry_nxt = retry_r + RETRY_ONE;
                        launch_s  = 1'b1;
                    end else begin
                        state_nxt    = ST_ERR;
                        error_nxt    = 1'b1;
                        err_idx_nxt  = idx_r;
                        err_code_nxt = ERR_RESP;
                    end
                end else if (timer_tc_s) begin
                    state_nxt    = ST_ERR;
                    b_ready_nxt  = 1'b0;
                    error_nxt    = 1'b1;
                    err_idx_nxt  = idx_r;
                    err_code_nxt = ERR_TIMEOUT;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                aw_valid_nxt = 1'b0;
                w_valid_nxt  = 1'b0;
                b_ready_nxt  = 1'b0;
                done_nxt     = 1'b0;
                error_nxt    = 1'b0;
            end
        endcase

        // A new attempt loads address/data for the selected entry and raises both valids.
        if (launch_s) begin
            state_nxt    = ST_ISSUE;
            aw_valid_nxt = 1'b1;
            w_valid_nxt  = 1'b1;
            aw_done_nxt  = 1'b0;
            w_done_nxt   = 1'b0;
            aw_addr_nxt  = entry_addr(idx_nxt);
            w_data_nxt   = entry_data(idx_nxt);
        end else begin
            aw_addr_nxt = aw_addr_nxt;
        end

        busy_nxt = (state_nxt == ST_ISSUE) || (state_nxt == ST_RESP);
    end

    assign aw_addr  = aw_addr_r;
    assign aw_valid = aw_valid_r;
    assign w_data   = w_data_r;
    assign w_valid  = w_valid_r;
    assign b_ready  = b_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;
    assign err_idx  = err_idx_r;
    assign err_code = err_code_r;

endmodule

// File: tb/tb_uart_cfg_seq.sv
module tb_uart_cfg_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  err_idx;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    // slave responder configuration and state
    int  aw_delay, w_delay, b_delay;
    bit  b_never;
    int  aw_cnt, w_cnt, b_cnt;
    bit  aw_got, w_got;
    int  w_first;
    int  valid_cnt;
    bit  proto_bad;
    bit  prev_aw_pend, prev_w_pend, prev_aw_hs, prev_w_hs;
    logic [31:0] prev_addr, prev_data;
    logic [1:0]  resp_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];

    // reference model outputs
    logic [1:0]  script_q[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic        exp_done, exp_err;
    logic [3:0]  exp_eidx;
    logic [1:0]  exp_code;

    int lat;
    bit found;

    uart_cfg_seq #(
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .aw_addr  (aw_addr),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_resp   (b_resp),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_idx  (err_idx),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tbl_addr(input int i);
        case (i)
            0:       return 32'h0001_0000;
            1:       return 32'h0001_001C;
            default: return 32'h0001_0010;
        endcase
    endfunction

    function automatic logic [31:0] tbl_data(input int i);
        case (i)
            0:       return 32'd2604;
            1:       return 32'h0000_0020;
            default: return 32'h0000_0048;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_clear();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 1'b0; w_got = 1'b0;
        w_first = 0; valid_cnt = 0; proto_bad = 1'b0;
        prev_aw_pend = 1'b0; prev_w_pend = 1'b0; prev_aw_hs = 1'b0; prev_w_hs = 1'b0;
        prev_addr = 32'h0; prev_data = 32'h0;
        aw_log.delete(); w_log.delete(); resp_q.delete();
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    endtask

    // One clock: at the falling edge, observe DUT outputs and drive the slave side
    // for the next rising edge; handshakes recorded here complete on that edge.
    task automatic cycle();
        bit hs_aw, hs_w, hs_b;
        @(negedge clk);
        if (rst) begin
            aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
            return;
        end
        if (prev_aw_pend && (aw_valid !== 1'b1 || aw_addr !== prev_addr)) proto_bad = 1'b1;
        if (prev_w_pend && (w_valid !== 1'b1 || w_data !== prev_data)) proto_bad = 1'b1;
        if (prev_aw_hs && aw_valid === 1'b1) proto_bad = 1'b1;
        if (prev_w_hs && w_valid === 1'b1) proto_bad = 1'b1;
        if (aw_valid || w_valid) valid_cnt++;

        aw_ready = aw_valid && (aw_cnt >= aw_delay);
        if (aw_valid && !aw_ready) aw_cnt++;
        hs_aw = aw_valid && aw_ready;
        w_ready = w_valid && (w_cnt >= w_delay);
        if (w_valid && !w_ready) w_cnt++;
        hs_w = w_valid && w_ready;

        if (aw_got && w_got && !b_never) begin
            if (b_cnt >= b_delay) begin
                b_valid = 1'b1;
                b_resp  = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
            end else begin
                b_cnt++;
                b_valid = 1'b0;
                b_resp  = 2'b00;
            end
        end else begin
            b_valid = 1'b0;
            b_resp  = 2'b00;
        end
        hs_b = b_valid && b_ready;
        if (hs_b) begin
            if (resp_q.size() > 0) void'(resp_q.pop_front());
            aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
        end
        if (hs_aw) begin
            aw_log.push_back(aw_addr);
            aw_cnt = 0;
            if (w_got) w_first++;
            aw_got = 1'b1;
        end
        if (hs_w) begin
            w_log.push_back(w_data);
            w_cnt = 0;
            w_got = 1'b1;
        end
        prev_aw_pend = aw_valid && !aw_ready;
        prev_w_pend  = w_valid && !w_ready;
        prev_aw_hs   = hs_aw;
        prev_w_hs    = hs_w;
        prev_addr    = aw_addr;
        prev_data    = w_data;
    endtask

    // Transaction-level model: walk the table, consuming one scripted response per attempt.
    task automatic model();
        int idx, tries, k;
        logic [1:0] r;
        exp_aw.delete(); exp_w.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_eidx = 4'd0; exp_code = 2'b00;
        idx = 0; tries = 0; k = 0;
        for (int g = 0; g < 64; g++) begin
            exp_aw.push_back(tbl_addr(idx));
            exp_w.push_back(tbl_data(idx));
            r = (k < script_q.size()) ? script_q[k] : 2'b00;
            k++;
            if (r == 2'b00) begin
                idx++; tries = 0;
                if (idx == 3) begin exp_done = 1'b1; break; end
            end else if (tries < 2) begin
                tries++;
            end else begin
                exp_err = 1'b1; exp_eidx = 4'(idx); exp_code = 2'b01; break;
            end
        end
    endtask

    task automatic run_seq(input int ad, input int wd, input int bd, input bit never, input bit poke);
        slave_clear();
        aw_delay = ad; w_delay = wd; b_delay = bd; b_never = never;
        foreach (script_q[i]) resp_q.push_back(script_q[i]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_clears", {27'd0, busy, done, error, err_code}, 32'h10);
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            start = (poke && lat == 4) ? 1'b1 : 1'b0;
            cycle();
            lat++;
            if (done || error) break;
        end
        start = 1'b0;
        check("seq_ends", {31'd0, done | error}, 32'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_aw_n"}, aw_log.size(), exp_aw.size());
        check({tag, "_w_n"}, w_log.size(), exp_w.size());
        for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++)
            check($sformatf("%s_aw%0d", tag, i), aw_log[i], exp_aw[i]);
        for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
            check($sformatf("%s_w%0d", tag, i), w_log[i], exp_w[i]);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_err_idx"}, {28'd0, err_idx}, {28'd0, exp_eidx});
        check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
        check({tag, "_proto"}, {31'd0, proto_bad}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; b_never = 1'b0;
        aw_delay = 0; w_delay = 0; b_delay = 0;
        slave_clear();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctl", {22'd0, aw_valid, w_valid, b_ready, busy, done, error, err_idx}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        check("rst_addr", aw_addr, 32'd0);
        check("rst_data", w_data, 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // defaults, everything immediate; also a start pulse while busy
        script_q.delete();
        model();
        run_seq(0, 0, 0, 1'b0, 1'b1);
        check("lat_default", lat, 32'd9);
        check_log("dflt");

        // address channel held off 3 cycles, data immediate
        script_q.delete();
        model();
        run_seq(3, 0, 0, 1'b0, 1'b0);
        check_log("awdly");
        check("w_first", w_first, 32'd3);

        // entry 1 answers SLVERR twice then OKAY
        script_q = '{2'b00, 2'b10, 2'b10, 2'b00};
        model();
        run_seq(0, 0, 0, 1'b0, 1'b0);
        check_log("retry_ok");
        check("retry_ok_n", aw_log.size(), 32'd5);

        // entry 2 answers SLVERR three times
        script_q = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
        model();
        run_seq(0, 0, 0, 1'b0, 1'b0);
        check_log("retry_err");
        valid_cnt = 0;
        repeat (5) cycle();
        check("no_valid_after_err", valid_cnt, 32'd0);
        check("err_held", {31'd0, error}, 32'd1);

        // response never arrives: timeout at cycle 16 of the first attempt
        script_q.delete();
        run_seq(0, 0, 0, 1'b1, 1'b0);
        check("to_lat", lat, 32'd16);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_code", {30'd0, err_code}, 32'h2);
        check("to_idx", {28'd0, err_idx}, 32'd0);
        check("to_drop", {28'd0, aw_valid, w_valid, b_ready, busy}, 32'd0);
        b_never = 1'b0;

        // reset while waiting for entry 1's response, then restart
        slave_clear();
        aw_delay = 0; w_delay = 0; b_delay = 3;
        start = 1'b1;
        cycle();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (aw_log.size() == 2 && b_ready === 1'b1) begin found = 1'b1; break; end
        end
        check("rst_reach_resp", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ctl", {22'd0, aw_valid, w_valid, b_ready, busy, done, error, err_idx}, 32'd0);
        check("midrst_addr", aw_addr, 32'd0);
        check("midrst_data", w_data, 32'd0);
        cycle();
        rst = 1'b0;
        slave_clear();
        repeat (3) cycle();
        check("no_resume", valid_cnt, 32'd0);
        script_q.delete();
        model();
        run_seq(0, 0, 0, 1'b0, 1'b0);
        check_log("restart");

        // randomized delays and response scripts against the model
        for (int t = 0; t < 6; t++) begin
            int n;
            script_q.delete();
            n = $urandom_range(0, 8);
            for (int j = 0; j < n; j++) begin
                int c;
                c = $urandom_range(0, 3);
                script_q.push_back((c < 2) ? 2'b00 : ((c == 2) ? 2'b10 : 2'b11));
            end
            model();
            run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
            check_log($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
